// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Shift/compare ops are stretched to SHIFT_LAT cycles; result and zero flag are captured for the owner.
module alu_share_arbiter #(
   parameter int DATA_W    = 64,
   parameter int SHIFT_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [3:0]        req_op0,
   input  logic [3:0]        req_op1,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_b1,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_next;
   logic              last_grant;
   logic              owner;
   logic              grant;
   logic              accept;
   logic              finish;
   logic              long_op;
   logic [3:0]        cnt;
   logic [3:0]        sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;

   // With both valid, the requester not granted last time wins.
   always_comb begin
      grant   = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
      accept  = (state == IDLE) && (|req_valid);
      finish  = (state == BUSY) && (cnt == 4'd0);
      sel_op  = grant ? req_op1 : req_op0;
      sel_a   = grant ? req_a1  : req_a0;
      sel_b   = grant ? req_b1  : req_b0;
      long_op = (sel_op >= 4'b0111) && (sel_op <= 4'b1010);
      req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
      busy    = (state != IDLE);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (finish) state_next = DONE;
         DONE:    if (rsp_ready[owner]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_op     <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= 4'd0;
         rsp_valid  <= 2'b00;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         if (accept) begin
            alu_op     <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= long_op ? 4'(SHIFT_LAT - 1) : 4'd0;
         end
         if (state == BUSY) begin
            if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_valid  <= owner ? 2'b10 : 2'b01;
            end
         end
         // The non-owner's rsp_ready never releases the response.
         if ((state == DONE) && rsp_ready[owner]) rsp_valid <= 2'b00;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized transaction-level check of alu_share_arbiter against a round-robin/latency model.
module tb_alu_share_arbiter;
   localparam int DATA_W    = 64;
   localparam int SHIFT_LAT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [3:0]        req_op0, req_op1, alu_op;
   logic [DATA_W-1:0] req_a0, req_a1, req_b0, req_b1;
   logic [DATA_W-1:0] rsp_result, alu_a, alu_b, alu_result;
   logic              rsp_zero, alu_zero, busy;

   int   n_cmp = 0;
   int   n_err = 0;
   logic model_lg;

   alu_share_arbiter #(.DATA_W(DATA_W), .SHIFT_LAT(SHIFT_LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return {63'd0, ($signed(a) < $signed(b))};
         4'b1000: return a << b[5:0];
         4'b1001: return a >> b[5:0];
         4'b1010: return 64'($signed(a) >>> b[5:0]);
         4'b1100: return ~(a | b);
         default: return a + b;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_model(alu_op, alu_a, alu_b);
      alu_zero   = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 with the arbiter idle.
   task automatic run_txn(input logic [1:0] v, input logic [3:0] o0, input logic [63:0] a0, input logic [63:0] b0,
                          input logic [3:0] o1, input logic [63:0] a1, input logic [63:0] b1, input int hold);
      logic        g;
      logic [1:0]  oh;
      logic [3:0]  op;
      logic [63:0] ea, eb, er;
      int          lat, n;
      g  = (v == 2'b11) ? ~model_lg : v[1];
      model_lg = g;
      oh = g ? 2'b10 : 2'b01;
      op = g ? o1 : o0;
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      lat = (op >= 4'd7 && op <= 4'd10) ? SHIFT_LAT : 1;
      er = alu_model(op, ea, eb);
      req_valid = v;
      req_op0 = o0; req_a0 = a0; req_b0 = b0;
      req_op1 = o1; req_a1 = a1; req_b1 = b1;
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(oh));
      chk("idle_busy", 64'(busy), 64'd0);
      tick();
      req_valid = req_valid & ~oh;
      @(negedge clk);
      chk("alu_op", 64'(alu_op), 64'(op));
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      n = 0;
      while (rsp_valid == 2'b00 && n < 40) begin
         chk("busy_noready", {61'd0, busy, req_ready}, 64'd4);
         tick();
         n++;
      end
      chk("latency", 64'(n), 64'(lat));
      chk("rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("rsp_result", rsp_result, er);
      chk("rsp_zero", 64'(rsp_zero), 64'(er == 64'd0));
      for (int k = 0; k < hold; k++) begin
         rsp_ready = (~oh) & 2'($urandom);
         tick();
         chk("hold_valid", 64'(rsp_valid), 64'(oh));
         chk("hold_result", rsp_result, er);
         chk("hold_busy", 64'(busy), 64'd1);
      end
      rsp_ready = oh;
      tick();
      rsp_ready = 2'b00;
      chk("release_valid", 64'(rsp_valid), 64'd0);
      chk("release_busy", 64'(busy), 64'd0);
      $display("txn v=%b grant=%0d op=%b lat=%0d result=%h", v, g, op, n, rsp_result);
   endtask

   initial begin
      logic [63:0] ra, rb, rc, rd;
      logic [1:0]  rv;
      reset = 1'b1;
      req_valid = 2'b00; rsp_ready = 2'b00;
      req_op0 = 4'd0; req_op1 = 4'd0;
      req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      model_lg = 1'b1;
      #12;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_result", rsp_result, 64'd0);
      chk("rst_alu", {alu_a | alu_b | 64'(alu_op) | 64'(rsp_zero) | 64'(busy)}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      run_txn(2'b01, 4'b0010, 64'd5, 64'd7, 4'b0000, 64'd0, 64'd0, 0);
      for (int i = 0; i < 4; i++)
         run_txn(2'b11, 4'b0110, 64'd9, 64'd9, 4'b0110, 64'd9, 64'd9, 0);
      run_txn(2'b11, 4'b0111, 64'd3, 64'd8, 4'b0010, 64'd1, 64'd2, 0);
      run_txn(2'b10, 4'b0111, 64'd3, 64'd8, 4'b0010, 64'd1, 64'd2, 10);

      for (int i = 0; i < 40; i++) begin
         rv = 2'($urandom_range(1, 3));
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
         rc = {$urandom, $urandom};
         rd = ($urandom_range(0, 3) == 0) ? rc : {$urandom, $urandom};
         run_txn(rv, 4'($urandom), ra, rb, 4'($urandom), rc, rd, $urandom_range(0, 4));
      end

      run_txn(2'b10, 4'b0000, 64'd0, 64'd0, 4'b1111, 64'd3, 64'd4, 0);

      // Reset in the middle of a long op drops it silently.
      req_valid = 2'b01; req_op0 = 4'b1001; req_a0 = 64'hF0; req_b0 = 64'd4;
      tick();
      req_valid = 2'b00;
      tick();
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_alu", alu_a | alu_b | 64'(alu_op), 64'd0);
      chk("midrst_result", rsp_result | 64'(rsp_zero), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      model_lg = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_quiet", {62'd0, rsp_valid}, 64'd0);
      end
      run_txn(2'b11, 4'b0010, 64'd1, 64'd1, 4'b0010, 64'd2, 64'd2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
